// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if
//   Bundles the decode-side inputs, the hazard controls and the registered
//   execute-side outputs of the ID/EX pipeline register.
//   Flow: there is no valid/ready handshake here. valid_d qualifies the decode
//   entry. The register always accepts on a clock edge unless the hazard unit
//   holds it with stall_e or replaces it with a bubble via flush_e.
//   Modports:
//     master : decode stage / hazard unit side, drives *_d, stall_e, flush_e
//     slave  : the pipeline register, drives *_e and bubble_cnt
interface id_ex_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // Hazard controls
  logic             stall_e;
  logic             flush_e;
  // Decode-side entry
  logic             valid_d;
  logic [2:0]       alu_control_d;
  logic             alu_src_d;
  logic             reg_write_d;
  logic             mem_write_d;
  logic [1:0]       result_src_d;
  logic             branch_d;
  logic             jump_d;
  logic [2:0]       funct3_d;
  logic [XLEN-1:0]  rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  // Execute-side entry
  logic             valid_e;
  logic [2:0]       alu_control_e;
  logic             alu_src_e;
  logic             reg_write_e;
  logic             mem_write_e;
  logic [1:0]       result_src_e;
  logic             branch_e;
  logic             jump_e;
  logic [2:0]       funct3_e;
  logic [XLEN-1:0]  rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output stall_e, flush_e, valid_d, alu_control_d, alu_src_d, reg_write_d,
           mem_write_d, result_src_d, branch_d, jump_d, funct3_d, rd1_d, rd2_d,
           imm_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
    input  valid_e, alu_control_e, alu_src_e, reg_write_e, mem_write_e,
           result_src_e, branch_e, jump_e, funct3_e, rd1_e, rd2_e, imm_e, pc_e,
           pc_plus4_e, rs1_e, rs2_e, rd_e, bubble_cnt
  );

  modport slave (
    input  stall_e, flush_e, valid_d, alu_control_d, alu_src_d, reg_write_d,
           mem_write_d, result_src_d, branch_d, jump_d, funct3_d, rd1_d, rd2_d,
           imm_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
    output valid_e, alu_control_e, alu_src_e, reg_write_e, mem_write_e,
           result_src_e, branch_e, jump_e, funct3_e, rd1_e, rd2_e, imm_e, pc_e,
           pc_plus4_e, rs1_e, rs2_e, rd_e, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   Decode->execute pipeline register of the 5-stage RISC-V core.
//   Per rising edge, in priority order:
//     flush_e          : load an all-zero bubble (even if stall_e is high)
//     stall_e          : hold the current E entry
//     otherwise        : capture the D entry (one cycle latency)
//   A captured entry with valid_d=0 is also a bubble: its side-effect
//   controls (reg_write, mem_write, branch, jump) are cleared.
//   bubble_cnt counts every bubble loaded into E and saturates at all-ones.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset, clears every output
//     bus    : id_ex_pipe_reg_if slave modport (*_d in, *_e and bubble_cnt out)
//   All outputs come straight from flops.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_pipe_reg_if.slave     bus
);

  typedef struct packed {
    logic            valid;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stage_t;

  stage_t           r_e;
  stage_t           w_load;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_bubble;

  // Entry to capture on a normal load. An invalid decode entry keeps its data
  // fields but must not write registers, memory or redirect the PC.
  always_comb begin
    w_load             = '0;
    w_load.valid       = bus.valid_d;
    w_load.alu_control = bus.alu_control_d;
    w_load.alu_src     = bus.alu_src_d;
    w_load.reg_write   = bus.reg_write_d & bus.valid_d;
    w_load.mem_write   = bus.mem_write_d & bus.valid_d;
    w_load.result_src  = bus.result_src_d;
    w_load.branch      = bus.branch_d & bus.valid_d;
    w_load.jump        = bus.jump_d & bus.valid_d;
    w_load.funct3      = bus.funct3_d;
    w_load.rd1         = bus.rd1_d;
    w_load.rd2         = bus.rd2_d;
    w_load.imm         = bus.imm_d;
    w_load.pc          = bus.pc_d;
    w_load.pc_plus4    = bus.pc_plus4_d;
    w_load.rs1         = bus.rs1_d;
    w_load.rs2         = bus.rs2_d;
    w_load.rd          = bus.rd_d;
  end

  // A bubble enters E on a flush, or on a load of an invalid entry.
  // A stall hold never counts.
  assign w_bubble = bus.flush_e | (~bus.stall_e & ~bus.valid_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e          <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (bus.flush_e) begin
        r_e <= '0;
      end else if (!bus.stall_e) begin
        r_e <= w_load;
      end
      if (w_bubble && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign bus.valid_e       = r_e.valid;
  assign bus.alu_control_e = r_e.alu_control;
  assign bus.alu_src_e     = r_e.alu_src;
  assign bus.reg_write_e   = r_e.reg_write;
  assign bus.mem_write_e   = r_e.mem_write;
  assign bus.result_src_e  = r_e.result_src;
  assign bus.branch_e      = r_e.branch;
  assign bus.jump_e        = r_e.jump;
  assign bus.funct3_e      = r_e.funct3;
  assign bus.rd1_e         = r_e.rd1;
  assign bus.rd2_e         = r_e.rd2;
  assign bus.imm_e         = r_e.imm;
  assign bus.pc_e          = r_e.pc;
  assign bus.pc_plus4_e    = r_e.pc_plus4;
  assign bus.rs1_e         = r_e.rs1;
  assign bus.rs2_e         = r_e.rs2;
  assign bus.rd_e          = r_e.rd;
  assign bus.bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg (XLEN=32, CNT_W=4 so saturation is reachable).
module tb_id_ex_pipe_reg;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            valid;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } entry_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  entry_t exp_e;
  int     exp_cnt;
  entry_t exp_q[$];   // expected E entries for the random run, in order

  function automatic void model_reset();
    exp_e   = '0;
    exp_cnt = 0;
  endfunction

  function automatic void model_count_bubble();
    if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
  endfunction

  // What the E stage should hold after one edge, derived from the stage rules.
  function automatic void model_edge(input logic fl, input logic st, input entry_t d);
    if (fl) begin
      exp_e = '0;
      model_count_bubble();
    end else if (!st) begin
      exp_e = d;
      if (!d.valid) begin
        exp_e.reg_write = 1'b0;
        exp_e.mem_write = 1'b0;
        exp_e.branch    = 1'b0;
        exp_e.jump      = 1'b0;
        model_count_bubble();
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic fl, input logic st, input entry_t d);
    bus.flush_e       = fl;
    bus.stall_e       = st;
    bus.valid_d       = d.valid;
    bus.alu_control_d = d.alu_control;
    bus.alu_src_d     = d.alu_src;
    bus.reg_write_d   = d.reg_write;
    bus.mem_write_d   = d.mem_write;
    bus.result_src_d  = d.result_src;
    bus.branch_d      = d.branch;
    bus.jump_d        = d.jump;
    bus.funct3_d      = d.funct3;
    bus.rd1_d         = d.rd1;
    bus.rd2_d         = d.rd2;
    bus.imm_d         = d.imm;
    bus.pc_d          = d.pc;
    bus.pc_plus4_d    = d.pc_plus4;
    bus.rs1_d         = d.rs1;
    bus.rs2_d         = d.rs2;
    bus.rd_d          = d.rd;
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic fl, input logic st, input entry_t d);
    drive(fl, st, d);
    @(posedge clk);
    #1;
    model_edge(fl, st, d);
  endtask

  // Asynchronous reset asserted and released between edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  function automatic entry_t get_e();
    entry_t e;
    e.valid       = bus.valid_e;
    e.alu_control = bus.alu_control_e;
    e.alu_src     = bus.alu_src_e;
    e.reg_write   = bus.reg_write_e;
    e.mem_write   = bus.mem_write_e;
    e.result_src  = bus.result_src_e;
    e.branch      = bus.branch_e;
    e.jump        = bus.jump_e;
    e.funct3      = bus.funct3_e;
    e.rd1         = bus.rd1_e;
    e.rd2         = bus.rd2_e;
    e.imm         = bus.imm_e;
    e.pc          = bus.pc_e;
    e.pc_plus4    = bus.pc_plus4_e;
    e.rs1         = bus.rs1_e;
    e.rs2         = bus.rs2_e;
    e.rd          = bus.rd_e;
    return e;
  endfunction

  function automatic entry_t rand_entry();
    entry_t d;
    d.valid       = ($urandom_range(0, 3) != 0);
    d.alu_control = 3'($urandom_range(0, 5));
    d.alu_src     = 1'($urandom);
    d.reg_write   = 1'($urandom);
    d.mem_write   = 1'($urandom);
    d.result_src  = 2'($urandom_range(0, 2));
    d.branch      = 1'($urandom);
    d.jump        = 1'($urandom);
    d.funct3      = 3'($urandom);
    d.rd1         = $urandom;
    d.rd2         = $urandom;
    d.imm         = $urandom;
    d.pc          = $urandom & 32'hFFFF_FFFC;
    d.pc_plus4    = d.pc + 32'd4;
    d.rs1         = 5'($urandom);
    d.rs2         = 5'($urandom);
    d.rd          = 5'($urandom);
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    entry_t e;
    drive(1'b0, 1'b0, '0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    e = get_e();
    n_checks++;
    if (e !== exp_e) begin
      n_fail++;
      $display("FAIL reset_entry: got %h expected %h", e, exp_e);
    end
    n_checks++;
    if (bus.bubble_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d expected 0", bus.bubble_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load();
    entry_t d;
    entry_t e;
    int     cnt_before;
    cnt_before    = exp_cnt;
    d             = rand_entry();
    d.valid       = 1'b1;
    d.alu_control = 3'b001;
    d.rd1         = 32'd5;
    d.rd2         = 32'd3;
    d.rd          = 5'd7;
    step(1'b0, 1'b0, d);
    e = get_e();
    n_checks++;
    if (e.alu_control !== 3'b001 || e.rd1 !== 32'd5 || e.rd2 !== 32'd3 ||
        e.rd !== 5'd7 || e.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_fields: got alu=%b rd1=%0d rd2=%0d rd=%0d valid=%b expected alu=001 rd1=5 rd2=3 rd=7 valid=1",
               e.alu_control, e.rd1, e.rd2, e.rd, e.valid);
    end
    n_checks++;
    if (e !== d) begin
      n_fail++;
      $display("FAIL load_entry: got %h expected %h", e, d);
    end
    n_checks++;
    if (int'(bus.bubble_cnt) != cnt_before) begin
      n_fail++;
      $display("FAIL load_cnt: got %0d expected %0d", bus.bubble_cnt, cnt_before);
    end
  endtask

  task automatic test_stall();
    entry_t held;
    entry_t e;
    int     cnt_before;
    held       = get_e();
    cnt_before = exp_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, rand_entry());
      e = get_e();
      n_checks++;
      if (e !== held) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, e, held);
      end
      n_checks++;
      if (int'(bus.bubble_cnt) != cnt_before) begin
        n_fail++;
        $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, bus.bubble_cnt, cnt_before);
      end
    end
  endtask

  task automatic test_flush_stall();
    entry_t e;
    int     cnt_before;
    cnt_before = exp_cnt;
    step(1'b1, 1'b1, rand_entry());
    e = get_e();
    n_checks++;
    if (e !== '0) begin
      n_fail++;
      $display("FAIL flush_entry: got %h expected 0", e);
    end
    n_checks++;
    if (int'(bus.bubble_cnt) != cnt_before + 1) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d expected %0d", bus.bubble_cnt, cnt_before + 1);
    end
  endtask

  task automatic test_invalid_load();
    entry_t d;
    entry_t e;
    int     cnt_before;
    cnt_before  = exp_cnt;
    d           = rand_entry();
    d.valid     = 1'b0;
    d.reg_write = 1'b1;
    d.mem_write = 1'b1;
    d.branch    = 1'b1;
    d.jump      = 1'b1;
    step(1'b0, 1'b0, d);
    e = get_e();
    n_checks++;
    if (e.reg_write !== 1'b0 || e.mem_write !== 1'b0 || e.branch !== 1'b0 ||
        e.jump !== 1'b0 || e.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_ctrl: got rw=%b mw=%b br=%b j=%b v=%b expected all 0",
               e.reg_write, e.mem_write, e.branch, e.jump, e.valid);
    end
    n_checks++;
    if (e.rd1 !== d.rd1 || e.imm !== d.imm || e.rd !== d.rd) begin
      n_fail++;
      $display("FAIL invalid_data: got rd1=%h imm=%h rd=%0d expected rd1=%h imm=%h rd=%0d",
               e.rd1, e.imm, e.rd, d.rd1, d.imm, d.rd);
    end
    n_checks++;
    if (int'(bus.bubble_cnt) != cnt_before + 1) begin
      n_fail++;
      $display("FAIL invalid_cnt: got %0d expected %0d", bus.bubble_cnt, cnt_before + 1);
    end
  endtask

  task automatic test_saturation();
    int want;
    async_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom), rand_entry());
      want = (i + 1 < CNT_MAX) ? i + 1 : CNT_MAX;
      n_checks++;
      if (int'(bus.bubble_cnt) != want) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, bus.bubble_cnt, want);
      end
    end
    // An invalid load after saturation must not wrap the counter.
    step(1'b0, 1'b0, '0);
    n_checks++;
    if (bus.bubble_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d expected 15", bus.bubble_cnt);
    end
  endtask

  task automatic test_random();
    entry_t e;
    entry_t want;
    logic   fl;
    logic   st;
    async_reset();
    for (int i = 0; i < 300; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 4) == 0);
      step(fl, st, rand_entry());
      exp_q.push_back(exp_e);
      e    = get_e();
      want = exp_q.pop_front();
      n_checks++;
      if (e !== want) begin
        n_fail++;
        $display("FAIL random_entry[%0d]: got %h expected %h", i, e, want);
      end
      n_checks++;
      if (int'(bus.bubble_cnt) != exp_cnt) begin
        n_fail++;
        $display("FAIL random_cnt[%0d]: got %0d expected %0d", i, bus.bubble_cnt, exp_cnt);
      end
    end
  endtask

  // Reset asserted while stall and flush are both active clears everything at once.
  task automatic test_reset_mid_op();
    entry_t d;
    entry_t e;
    d       = rand_entry();
    d.valid = 1'b1;
    step(1'b0, 1'b0, d);
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
    drive(1'b1, 1'b1, rand_entry());
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    e = get_e();
    n_checks++;
    if (e !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_entry: got %h expected 0", e);
    end
    n_checks++;
    if (bus.bubble_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL midop_reset_cnt: got %0d expected 0", bus.bubble_cnt);
    end
    // Still inside reset across an edge: nothing may be captured.
    @(posedge clk);
    #1;
    n_checks++;
    if (get_e() !== '0 || bus.bubble_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL midop_reset_hold: got %h cnt=%0d expected 0 cnt=0", get_e(), bus.bubble_cnt);
    end
    rst_n = 1'b1;
    // First edge after release captures the D entry.
    d       = rand_entry();
    d.valid = 1'b1;
    step(1'b0, 1'b0, d);
    n_checks++;
    if (get_e() !== d) begin
      n_fail++;
      $display("FAIL post_reset_load: got %h expected %h", get_e(), d);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_invalid_load();
    test_saturation();
    test_random();
    test_reset_mid_op();
    test_load();
    @(posedge clk);
    #3;
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
